fetch_pc_unit: RTL and testbench

//  Program-counter / fetch-control stage directly downstream of the ALU's branch output.

---
 rtl/fetch_pc_if.sv | 32 +++
 rtl/fetch_pc_unit.sv | 75 +++++++
 tb/tb_fetch_pc_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/fetch_pc_if.sv
// fetch_pc_if: fetch/PC control bus between the decoder/ALU side and the PC unit
interface fetch_pc_if #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
);
    logic             start;
    logic [PC_W-1:0]  start_addr;
    logic             stall;
    logic             halt_req;
    logic             branch_en;
    logic             branch;
    logic [IDX_W-1:0] target_idx;
    logic             lut_wr_en;
    logic [IDX_W-1:0] lut_wr_idx;
    logic [PC_W-1:0]  lut_wr_data;
    logic [PC_W-1:0]  pc;
    logic             running;
    logic             done;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] cyc_count;
    modport master (
        output start, start_addr, stall, halt_req, branch_en, branch, target_idx,
               lut_wr_en, lut_wr_idx, lut_wr_data,
        input  pc, running, done, br_count, cyc_count
    );
    modport slave (
        input  start, start_addr, stall, halt_req, branch_en, branch, target_idx,
               lut_wr_en, lut_wr_idx, lut_wr_data,
        output pc, running, done, br_count, cyc_count
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: next-PC selection (restart/hold/halt/LUT branch/increment) with run state and counters
module fetch_pc_unit #(
    parameter int PC_W  = 10,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input logic       clk,
    input logic       reset,
    fetch_pc_if.slave bus
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] HALT = 2'b10;
    logic [1:0]       state, nxt_state;
    logic [PC_W-1:0]  nxt_pc;
    logic [CNT_W-1:0] nxt_br, nxt_cyc;
    logic [PC_W-1:0]  lut [2**IDX_W];
    logic             take;
    function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction
    // branch_en gates first so an X on branch cannot reach the PC mux when no branch is decoded
    assign take = bus.branch_en && bus.branch;
    always_comb begin
        nxt_state = state;
        nxt_pc    = bus.pc;
        nxt_br    = bus.br_count;
        nxt_cyc   = bus.cyc_count;
        if (bus.start) begin
            nxt_state = RUN;
            nxt_pc    = bus.start_addr;
            nxt_br    = '0;
            nxt_cyc   = '0;
        end else if (state == RUN) begin
            if (!bus.stall) begin
                nxt_cyc = sat(bus.cyc_count);
                if (bus.halt_req) begin
                    nxt_state = HALT;
                end else if (take) begin
                    nxt_pc = lut[bus.target_idx];
                    nxt_br = sat(bus.br_count);
                end else begin
                    nxt_pc = bus.pc + 1'b1;
                end
            end
        end else if (state != IDLE && state != HALT) begin
            nxt_state = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bus.pc        <= '0;
            bus.running   <= 1'b0;
            bus.done      <= 1'b0;
            bus.br_count  <= '0;
            bus.cyc_count <= '0;
        end else begin
            state         <= nxt_state;
            bus.pc        <= nxt_pc;
            bus.running   <= nxt_state == RUN;
            bus.done      <= nxt_state == HALT;
            bus.br_count  <= nxt_br;
            bus.cyc_count <= nxt_cyc;
        end
    end
    // write lands after the combinational read, so a same-cycle branch sees the old entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**IDX_W; i++) lut[i] <= '0;
        end else if (bus.lut_wr_en) begin
            lut[bus.lut_wr_idx] <= bus.lut_wr_data;
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed checks of PC selection, run/halt state, counters and LUT behaviour
module tb_fetch_pc_unit;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    always #5 clk = ~clk;
    fetch_pc_if #(.PC_W(10), .IDX_W(4), .CNT_W(16)) bus ();
    fetch_pc_unit #(.PC_W(10), .IDX_W(4), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag, input logic [9:0] pc, input logic run,
                           input logic dn, input logic [15:0] br, input logic [15:0] cyc);
        chk({tag, ".pc"}, 32'(bus.pc), 32'(pc));
        chk({tag, ".running"}, 32'(bus.running), 32'(run));
        chk({tag, ".done"}, 32'(bus.done), 32'(dn));
        chk({tag, ".br_count"}, 32'(bus.br_count), 32'(br));
        chk({tag, ".cyc_count"}, 32'(bus.cyc_count), 32'(cyc));
    endtask
    task automatic lut_write(input logic [3:0] idx, input logic [9:0] data);
        bus.lut_wr_en   = 1'b1;
        bus.lut_wr_idx  = idx;
        bus.lut_wr_data = data;
        step();
        bus.lut_wr_en = 1'b0;
    endtask
    task automatic do_start(input logic [9:0] addr);
        bus.start      = 1'b1;
        bus.start_addr = addr;
        step();
        bus.start = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        bus.start = 0; bus.start_addr = '0; bus.stall = 0; bus.halt_req = 0;
        bus.branch_en = 0; bus.branch = 0; bus.target_idx = '0;
        bus.lut_wr_en = 0; bus.lut_wr_idx = '0; bus.lut_wr_data = '0;
        step();
        step();
        chk_all("reset", 10'h000, 0, 0, 0, 0);
        reset = 1'b0;
        lut_write(4'd3, 10'h200);
        lut_write(4'd5, 10'h0AA);
        lut_write(4'd7, 10'h050);
        chk_all("idle_hold", 10'h000, 0, 0, 0, 0);
        do_start(10'h010);
        chk_all("start", 10'h010, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("seq.pc", 32'(bus.pc), 32'h010 + 32'(i));
        end
        chk_all("seq_end", 10'h014, 1, 0, 0, 4);
        bus.branch_en = 1; bus.branch = 1; bus.target_idx = 4'd3;
        step();
        chk_all("br_taken", 10'h200, 1, 0, 1, 5);
        bus.branch = 0;
        step();
        chk_all("br_not_taken", 10'h201, 1, 0, 1, 6);
        bus.branch = 1; bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("stall", 10'h201, 1, 0, 1, 6);
        end
        bus.stall = 0;
        step();
        chk_all("after_stall", 10'h200, 1, 0, 2, 7);
        bus.target_idx = 4'd7;
        step();
        chk_all("br_to_050", 10'h050, 1, 0, 3, 8);
        bus.halt_req = 1; bus.target_idx = 4'd3;
        step();
        chk_all("halt", 10'h050, 0, 1, 3, 9);
        bus.stall = 1;
        step();
        chk_all("halt_hold", 10'h050, 0, 1, 3, 9);
        bus.stall = 0; bus.halt_req = 0; bus.branch_en = 0; bus.branch = 0;
        do_start(10'h000);
        chk_all("restart", 10'h000, 1, 0, 0, 0);
        do_start(10'h3FF);
        chk_all("start_3ff", 10'h3FF, 1, 0, 0, 0);
        bus.branch = 1'bx;
        step();
        chk_all("wrap_x_branch", 10'h000, 1, 0, 0, 1);
        bus.branch_en = 1; bus.branch = 1; bus.target_idx = 4'd5;
        bus.lut_wr_en = 1; bus.lut_wr_idx = 4'd5; bus.lut_wr_data = 10'h123;
        step();
        bus.lut_wr_en = 0;
        chk_all("wr_rd_same", 10'h0AA, 1, 0, 1, 2);
        step();
        chk_all("new_entry", 10'h123, 1, 0, 2, 3);
        bus.branch_en = 0; bus.branch = 0;
        reset = 1'b1;
        step();
        chk_all("reset_mid_run", 10'h000, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        chk_all("post_reset_idle", 10'h000, 0, 0, 0, 0);
        do_start(10'h040);
        bus.branch_en = 1; bus.branch = 1; bus.target_idx = 4'd3;
        step();
        chk_all("lut_cleared", 10'h000, 1, 0, 1, 1);
        bus.branch_en = 0; bus.branch = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
